// File: rtl/fwd_sel_if.sv
// Decode-side bundle between the ID stage and the forwarding/hazard unit.
// master = decode/ID pipeline control, slave = fwd_sel_unit.
interface fwd_sel_if #(
  parameter int ADDR_W = 5
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic              id_rs_used;
  logic [ADDR_W-1:0] id_rt;
  logic              id_rt_used;
  logic              id_wr_en;
  logic [ADDR_W-1:0] id_wr_addr;
  logic              id_is_load;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_wr_addr, id_is_load, flush,
    input  stall, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_wr_addr, id_is_load, flush,
    output stall, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/fwd_sel_unit.sv
// Forwarding select and load-use stall generation for the 5-stage pipeline.
// Tracks in-flight destinations (EX/MEM/WB) fed from decode.
module fwd_sel_unit #(
  parameter int ADDR_W = 5
) (
  input  logic      clk,
  input  logic      rst,
  fwd_sel_if.slave  bus
);

  logic              ex_valid_q, ex_wr_en_q, ex_load_q;
  logic [ADDR_W-1:0] ex_addr_q;
  logic              mem_valid_q, mem_wr_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              wb_valid_q, wb_wr_en_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [1:0]        sel_a_q, sel_b_q;
  logic [1:0]        sel_a_d, sel_b_d;

  logic ex_prod, mem_prod, wb_prod;
  logic load_hit, stall_w, advance;

  assign ex_prod  = ex_valid_q  & ex_wr_en_q  & (ex_addr_q  != '0);
  assign mem_prod = mem_valid_q & mem_wr_en_q & (mem_addr_q != '0);
  assign wb_prod  = wb_valid_q  & wb_wr_en_q  & (wb_addr_q  != '0);

  assign load_hit = (bus.id_rs_used & (bus.id_rs == ex_addr_q)) |
                    (bus.id_rt_used & (bus.id_rt == ex_addr_q));
  assign stall_w  = bus.id_valid & ex_prod & ex_load_q & load_hit & ~bus.flush;
  assign advance  = bus.id_valid & ~stall_w & ~bus.flush;

  // The slot a producer occupies now is one stage older by the time the
  // consumer sits in EX, hence EX->01, MEM->10, WB->11 (post-WB latch).
  always_comb begin
    sel_a_d = 2'b00;
    if (bus.id_rs_used && (bus.id_rs != '0)) begin
      if (ex_prod && (bus.id_rs == ex_addr_q))        sel_a_d = 2'b01;
      else if (mem_prod && (bus.id_rs == mem_addr_q)) sel_a_d = 2'b10;
      else if (wb_prod && (bus.id_rs == wb_addr_q))   sel_a_d = 2'b11;
    end
    sel_b_d = 2'b00;
    if (bus.id_rt_used && (bus.id_rt != '0)) begin
      if (ex_prod && (bus.id_rt == ex_addr_q))        sel_b_d = 2'b01;
      else if (mem_prod && (bus.id_rt == mem_addr_q)) sel_b_d = 2'b10;
      else if (wb_prod && (bus.id_rt == wb_addr_q))   sel_b_d = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_wr_en_q  <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_addr_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_wr_en_q  <= 1'b0;
      wb_addr_q   <= '0;
      sel_a_q     <= 2'b00;
      sel_b_q     <= 2'b00;
    end else begin
      wb_valid_q  <= mem_valid_q;
      wb_wr_en_q  <= mem_wr_en_q;
      wb_addr_q   <= mem_addr_q;
      mem_valid_q <= ex_valid_q;
      mem_wr_en_q <= ex_wr_en_q;
      mem_addr_q  <= ex_addr_q;
      ex_valid_q  <= advance;
      ex_wr_en_q  <= advance & bus.id_wr_en;
      ex_load_q   <= advance & bus.id_is_load;
      ex_addr_q   <= advance ? bus.id_wr_addr : '0;
      sel_a_q     <= advance ? sel_a_d : 2'b00;
      sel_b_q     <= advance ? sel_b_d : 2'b00;
    end
  end

  assign bus.stall     = stall_w;
  assign bus.fwd_a_sel = sel_a_q;
  assign bus.fwd_b_sel = sel_b_q;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Bench for fwd_sel_unit: directed pipeline scenarios with literal expectations,
// then random instruction streams checked every cycle against a slot-list model.
module tb_fwd_sel_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fwd_sel_if #(.ADDR_W(5)) bus ();

  fwd_sel_unit #(.ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit       v;
    bit       we;
    bit       ld;
    bit [4:0] a;
  } slot_t;

  slot_t    pipe [3];
  bit [1:0] m_sel_a = 2'b00;
  bit [1:0] m_sel_b = 2'b00;

  function automatic bit is_prod(int i);
    return pipe[i].v && pipe[i].we && (pipe[i].a != 5'd0);
  endfunction

  function automatic bit [1:0] model_sel(bit [4:0] src, bit used);
    if (!used || src == 5'd0) return 2'b00;
    for (int i = 0; i < 3; i++)
      if (is_prod(i) && pipe[i].a == src) return 2'(i + 1);
    return 2'b00;
  endfunction

  function automatic bit model_stall();
    bit hit;
    hit = (bus.id_rs_used && bus.id_rs == pipe[0].a) ||
          (bus.id_rt_used && bus.id_rt == pipe[0].a);
    return bus.id_valid && !bus.flush && is_prod(0) && pipe[0].ld && hit;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
      m_sel_a = 2'b00;
      m_sel_b = 2'b00;
    end else begin
      bit adv;
      adv = bus.id_valid && !bus.flush && !model_stall();
      m_sel_a = adv ? model_sel(bus.id_rs, bus.id_rs_used) : 2'b00;
      m_sel_b = adv ? model_sel(bus.id_rt, bus.id_rt_used) : 2'b00;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{v: adv, we: adv && bus.id_wr_en, ld: adv && bus.id_is_load,
                  a: adv ? bus.id_wr_addr : 5'd0};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.stall !== model_stall() || bus.fwd_a_sel !== m_sel_a ||
          bus.fwd_b_sel !== m_sel_b) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got stall=%b a=%b b=%b, want stall=%b a=%b b=%b",
                 $time, bus.stall, bus.fwd_a_sel, bus.fwd_b_sel,
                 model_stall(), m_sel_a, m_sel_b);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(bit v, int rs, bit ru, int rt, bit tu, bit we, int wa, bit ld, bit fl);
    bus.id_valid   = v;
    bus.id_rs      = 5'(rs);
    bus.id_rs_used = ru;
    bus.id_rt      = 5'(rt);
    bus.id_rt_used = tu;
    bus.id_wr_en   = we;
    bus.id_wr_addr = 5'(wa);
    bus.id_is_load = ld;
    bus.flush      = fl;
  endtask

  task automatic issue(bit v, int rs, bit ru, int rt, bit tu, bit we, int wa, bit ld, bit fl);
    @(posedge clk);
    #1;
    drive(v, rs, ru, rt, tu, we, wa, ld, fl);
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  initial begin
    bit held;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_stall", bus.stall, 0);
    chk("reset_sel_a", bus.fwd_a_sel, 0);
    chk("reset_sel_b", bus.fwd_b_sel, 0);
    @(negedge clk);
    rst = 1'b0;

    // add r1,r2,r3 ; add r2,r1,r4
    issue(1, 2, 1, 3, 1, 1, 1, 0, 0);
    issue(1, 1, 1, 4, 1, 1, 2, 0, 0);
    chk("t1_stall", bus.stall, 0);
    nop();
    chk("t1_sel_a", bus.fwd_a_sel, 1);
    chk("t1_sel_b", bus.fwd_b_sel, 0);
    drain();

    // producer r5, consumer at distance 2/3/4
    for (int d = 2; d <= 4; d++) begin
      issue(1, 0, 0, 0, 0, 1, 5, 0, 0);
      repeat (d - 1) nop();
      issue(1, 5, 1, 0, 0, 1, 9, 0, 0);
      nop();
      chk($sformatf("t2_dist%0d_sel_a", d), bus.fwd_a_sel, (d == 2) ? 2 : (d == 3) ? 3 : 0);
      drain();
    end

    // lw r3 ; sub r6,r7,r3
    issue(1, 0, 0, 0, 0, 1, 3, 1, 0);
    issue(1, 7, 1, 3, 1, 1, 6, 0, 0);
    chk("t3_stall_on", bus.stall, 1);
    issue(1, 7, 1, 3, 1, 1, 6, 0, 0);
    chk("t3_stall_off", bus.stall, 0);
    chk("t3_bubble_sel_b", bus.fwd_b_sel, 0);
    nop();
    chk("t3_sel_b", bus.fwd_b_sel, 2);
    chk("t3_sel_a", bus.fwd_a_sel, 0);
    drain();

    // r0 never forwarded; youngest r1 wins
    issue(1, 0, 0, 0, 0, 1, 0, 0, 0);
    issue(1, 0, 1, 0, 1, 0, 0, 0, 0);
    nop();
    chk("t4_r0_sel_a", bus.fwd_a_sel, 0);
    chk("t4_r0_sel_b", bus.fwd_b_sel, 0);
    issue(1, 0, 0, 0, 0, 1, 1, 0, 0);
    issue(1, 0, 0, 0, 0, 1, 1, 0, 0);
    issue(1, 1, 1, 0, 0, 1, 8, 0, 0);
    nop();
    chk("t4_youngest_sel_a", bus.fwd_a_sel, 1);
    drain();

    // lw r3 ; use r3 flushed
    issue(1, 0, 0, 0, 0, 1, 3, 1, 0);
    issue(1, 3, 1, 0, 0, 1, 6, 0, 1);
    chk("t5_flush_stall", bus.stall, 0);
    issue(1, 8, 1, 9, 1, 1, 10, 0, 0);
    chk("t5_bubble_sel_a", bus.fwd_a_sel, 0);
    nop();
    chk("t5_sel_a", bus.fwd_a_sel, 0);
    chk("t5_sel_b", bus.fwd_b_sel, 0);
    drain();

    // reset during a stall with three producers in flight
    issue(1, 0, 0, 0, 0, 1, 10, 0, 0);
    issue(1, 10, 1, 0, 0, 1, 11, 0, 0);
    issue(1, 11, 1, 0, 0, 1, 12, 1, 0);
    issue(1, 12, 1, 0, 0, 0, 0, 0, 0);
    chk("t6_stall_before", bus.stall, 1);
    chk("t6_sel_a_before", bus.fwd_a_sel, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", bus.stall, 0);
    chk("t6_rst_sel_a", bus.fwd_a_sel, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1, 12, 1, 11, 1, 0, 0, 0, 0);
    chk("t6_post_stall", bus.stall, 0);
    nop();
    chk("t6_post_sel_a", bus.fwd_a_sel, 0);
    chk("t6_post_sel_b", bus.fwd_b_sel, 0);
    drain();

    // random streams over a small register set so hazards are frequent
    held = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (!held) begin
        drive(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
      end else begin
        bus.flush = ($urandom_range(0, 7) == 0);
      end
      if (n == 1500) begin
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      #1;
      held = bus.stall;
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
